// File: rtl/calc_seq_pkg.sv
// Shared constants for the calculator keypad sequencer: operand sizing,
// FSM state encodings and key codes.
package calc_pkg;
    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;
    localparam int CNT_W  = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ENT_A = 3'd1,
        S_LD_A  = 3'd2,
        S_ENT_B = 3'd3,
        S_LD_B  = 3'd4,
        S_EXEC  = 3'd5,
        S_LD_R  = 3'd6,
        S_SHOW  = 3'd7
    } state_t;

    localparam logic [3:0] KEY_ADD     = 4'hA;
    localparam logic [3:0] KEY_SUB     = 4'hB;
    localparam logic [3:0] KEY_EQ      = 4'hF;
    localparam logic [3:0] KEY_DIG_MAX = 4'h9;
endpackage

// File: rtl/calc_seq_if.sv
// Keypad-side inputs and datapath-side controls of the calculator sequencer.
interface calc_seq_if;
    import calc_pkg::*;

    logic         trig;
    logic [3:0]   value;
    logic [W-1:0] Operand;
    logic         LoadA;
    logic         LoadB;
    logic         LoadR;
    logic         AddSub;
    logic         SelR;
    logic         ShowR;
    logic         Busy;
    logic         Err;
    logic [2:0]   debug;

    modport master (
        output trig, value,
        input  Operand, LoadA, LoadB, LoadR, AddSub, SelR, ShowR, Busy, Err, debug
    );

    modport slave (
        input  trig, value,
        output Operand, LoadA, LoadB, LoadR, AddSub, SelR, ShowR, Busy, Err, debug
    );
endinterface

// File: rtl/calc_seq_key_sync.sv
// Two-flop synchronizer for the raw key strobe with a rising-edge detector,
// giving exactly one press pulse per key press however long it is held.
module key_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic trig,
    output logic press
);
    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= trig;
            sync <= meta;
            prev <= sync;
        end
    end

    assign press = sync & ~prev;
endmodule

// File: rtl/calc_seq.sv
// Entry controller for the two-function calculator: assembles hex operands,
// sequences the A/B/R register loads and supports result chaining.
module calc_seq
    import calc_pkg::*;
(
    input  logic      Clk,
    input  logic      ClrA,
    input  logic      ClrE,
    calc_seq_if.slave bus
);
    state_t         state;
    logic [W-1:0]   operand;
    logic [CNT_W-1:0] cnt;
    logic           add_sub;
    logic           err;
    logic           selr_flag;
    logic           press;
    logic           is_digit;
    logic           is_op;
    logic           is_eq;
    logic           room;
    logic [W-1:0]   shifted;

    key_sync u_key_sync (
        .clk   (Clk),
        .rst_n (ClrA),
        .trig  (bus.trig),
        .press (press)
    );

    assign is_digit = (bus.value <= KEY_DIG_MAX);
    assign is_op    = (bus.value == KEY_ADD) || (bus.value == KEY_SUB);
    assign is_eq    = (bus.value == KEY_EQ);
    assign room     = (cnt < CNT_W'(DIGITS));
    assign shifted  = {operand[W-5:0], bus.value};

    // Busy states never look at press, so keys arriving there are simply lost.
    always_ff @(posedge Clk or negedge ClrA) begin
        if (!ClrA) begin
            state     <= S_IDLE;
            operand   <= '0;
            cnt       <= '0;
            add_sub   <= 1'b0;
            err       <= 1'b0;
            selr_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    operand   <= '0;
                    cnt       <= '0;
                    err       <= 1'b0;
                    selr_flag <= 1'b0;
                    state     <= S_ENT_A;
                end
                S_ENT_A, S_ENT_B: begin
                    if (!ClrE) begin
                        operand <= '0;
                        cnt     <= '0;
                        err     <= 1'b0;
                    end else if (press) begin
                        if (is_digit) begin
                            if (room) begin
                                operand <= shifted;
                                cnt     <= cnt + 1'b1;
                            end else begin
                                err <= 1'b1;
                            end
                        end else if (is_op) begin
                            add_sub <= (bus.value == KEY_SUB);
                            if (state == S_ENT_A) state <= S_LD_A;
                        end else if (is_eq && state == S_ENT_B) begin
                            state <= S_LD_B;
                        end
                    end
                end
                S_LD_A: begin
                    operand <= '0;
                    cnt     <= '0;
                    state   <= S_ENT_B;
                end
                S_LD_B: state <= S_EXEC;
                S_EXEC: state <= S_LD_R;
                S_LD_R: state <= S_SHOW;
                S_SHOW: begin
                    if (press && is_digit) begin
                        operand   <= {{(W-4){1'b0}}, bus.value};
                        cnt       <= CNT_W'(1);
                        err       <= 1'b0;
                        selr_flag <= 1'b0;
                        state     <= S_ENT_A;
                    end else if (press && is_op) begin
                        // Chaining: A is reloaded from the result register, not the keypad.
                        add_sub   <= (bus.value == KEY_SUB);
                        selr_flag <= 1'b1;
                        operand   <= '0;
                        cnt       <= '0;
                        state     <= S_LD_A;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.Operand = operand;
    assign bus.LoadA   = (state != S_LD_A);
    assign bus.LoadB   = (state != S_LD_B);
    assign bus.LoadR   = (state != S_LD_R);
    assign bus.AddSub  = add_sub;
    assign bus.SelR    = (state == S_LD_A) && selr_flag;
    assign bus.ShowR   = (state == S_SHOW);
    assign bus.Busy    = (state == S_LD_A) || (state == S_LD_B) ||
                         (state == S_EXEC) || (state == S_LD_R);
    assign bus.Err     = err;
    assign bus.debug   = state;
endmodule

// File: tb/tb_calc_seq.sv
// Self-checking bench for calc_seq: load strobes are checked by a scoreboard
// monitor, register state by direct checks after each key.
module tb_calc_seq;
    logic Clk;
    logic ClrA;
    logic ClrE;
    int   cyc;
    int   testsRun;
    int   testsFailed;
    int   base;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] operand;
        logic       addSub;
        logic       selR;
        bit         chk;
    } expT;

    expT expQ[$];

    calc_seq_if bus ();

    calc_seq dut (
        .Clk  (Clk),
        .ClrA (ClrA),
        .ClrE (ClrE),
        .bus  (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc++;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic pushExp(input int kind, input int c, input logic [7:0] op,
                           input logic addSub, input logic selR, input bit chk);
        expT e;
        e.kind = kind; e.cyc = c; e.operand = op; e.addSub = addSub; e.selR = selR; e.chk = chk;
        expQ.push_back(e);
    endtask

    // Called and returns one time unit after a rising clock edge.
    task automatic applyStimulus(input logic [3:0] v, input int hold);
        bus.value = v;
        bus.trig  = 1'b1;
        repeat (hold) @(posedge Clk);
        #1 bus.trig = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
    endtask

    // Scoreboard monitor: every load strobe must match the oldest expectation.
    always @(negedge Clk) begin
        if (ClrA && (!bus.LoadA || !bus.LoadB || !bus.LoadR)) begin
            int kind;
            kind = !bus.LoadA ? 0 : (!bus.LoadB ? 1 : 2);
            testsRun++;
            if (expQ.size() == 0) begin
                testsFailed++;
                $display("[TB] FAIL unexpected load: kind %0d at cycle %0d, none expected", kind, cyc);
            end else begin
                expT e;
                e = expQ.pop_front();
                if (kind != e.kind || cyc != e.cyc ||
                    (e.chk && (bus.Operand !== e.operand || bus.AddSub !== e.addSub || bus.SelR !== e.selR))) begin
                    testsFailed++;
                    $display("[TB] FAIL load event: got kind %0d cyc %0d op 0x%0h as %0b selr %0b, want kind %0d cyc %0d op 0x%0h as %0b selr %0b",
                             kind, cyc, bus.Operand, bus.AddSub, bus.SelR,
                             e.kind, e.cyc, e.operand, e.addSub, e.selR);
                end
            end
        end
    end

    initial begin
        cyc = 0; testsRun = 0; testsFailed = 0;
        ClrA = 1'b0; ClrE = 1'b1; bus.trig = 1'b0; bus.value = 4'h0;

        // Reset state
        repeat (3) @(posedge Clk);
        #1;
        checkOutput("rst debug", 32'(bus.debug), 32'd0);
        checkOutput("rst loads", {29'd0, bus.LoadA, bus.LoadB, bus.LoadR}, 32'h7);
        checkOutput("rst operand", 32'(bus.Operand), 32'h0);
        checkOutput("rst flags", {27'd0, bus.AddSub, bus.SelR, bus.ShowR, bus.Busy, bus.Err}, 32'h0);
        ClrA = 1'b1;
        #1 checkOutput("release idle", 32'(bus.debug), 32'd0);
        @(posedge Clk); #1;
        checkOutput("release ent_a", 32'(bus.debug), 32'd1);

        // Keys 1,2,A,3,4,F
        applyStimulus(4'h1, 4);
        checkOutput("digit 1", 32'(bus.Operand), 32'h01);
        applyStimulus(4'h2, 4);
        checkOutput("digit 2", 32'(bus.Operand), 32'h12);
        base = cyc; pushExp(0, base + 3, 8'h12, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'hA, 4);
        checkOutput("ent_b", 32'(bus.debug), 32'd3);
        applyStimulus(4'h3, 4);
        applyStimulus(4'h4, 4);
        checkOutput("operand b", 32'(bus.Operand), 32'h34);
        base = cyc;
        pushExp(1, base + 3, 8'h34, 1'b0, 1'b0, 1'b1);
        pushExp(2, base + 5, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'hF, 4);
        checkOutput("show state", {28'd0, bus.debug, bus.ShowR}, {28'd0, 3'd7, 1'b1});

        // Chaining from SHOW
        base = cyc; pushExp(0, base + 3, 8'h00, 1'b1, 1'b1, 1'b1);
        applyStimulus(4'hB, 4);
        applyStimulus(4'h7, 4);
        base = cyc;
        pushExp(1, base + 3, 8'h07, 1'b1, 1'b0, 1'b1);
        pushExp(2, base + 5, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'hF, 4);
        checkOutput("chain show", 32'(bus.debug), 32'd7);

        // Overflow and clear-entry
        applyStimulus(4'h1, 4);
        checkOutput("show digit", {23'd0, bus.debug, bus.Operand, bus.Err}, {23'd0, 3'd1, 8'h01, 1'b0});
        applyStimulus(4'h2, 4);
        applyStimulus(4'h3, 4);
        checkOutput("overflow", {23'd0, bus.Operand, bus.Err}, {23'd0, 8'h12, 1'b1});
        ClrE = 1'b0;
        @(posedge Clk); #1 ClrE = 1'b1;
        checkOutput("clear entry", {20'd0, bus.debug, bus.AddSub, bus.Operand, bus.Err}, {20'd0, 3'd1, 1'b1, 8'h00, 1'b0});
        applyStimulus(4'h5, 4);
        checkOutput("after clear", 32'(bus.Operand), 32'h05);

        // Held key, ignored keys, F in ENT_A
        ClrE = 1'b0;
        @(posedge Clk); #1 ClrE = 1'b1;
        applyStimulus(4'h4, 10);
        checkOutput("held key", 32'(bus.Operand), 32'h04);
        applyStimulus(4'hC, 4);
        applyStimulus(4'hD, 4);
        applyStimulus(4'hE, 4);
        applyStimulus(4'hF, 4);
        checkOutput("ignored keys", {20'd0, bus.debug, bus.Operand, bus.Err}, {20'd0, 3'd1, 8'h04, 1'b0});
        applyStimulus(4'h6, 4);
        checkOutput("second digit", {23'd0, bus.Operand, bus.Err}, {23'd0, 8'h46, 1'b0});
        applyStimulus(4'h7, 4);
        checkOutput("third digit", {23'd0, bus.Operand, bus.Err}, {23'd0, 8'h46, 1'b1});

        // Reset during EXEC
        base = cyc; pushExp(0, base + 3, 8'h46, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'hA, 4);
        applyStimulus(4'h9, 4);
        base = cyc; pushExp(1, base + 3, 8'h09, 1'b0, 1'b0, 1'b1);
        bus.value = 4'hF;
        bus.trig  = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        checkOutput("exec state", {28'd0, bus.debug, bus.Busy}, {28'd0, 3'd5, 1'b1});
        #2 ClrA = 1'b0;
        #1;
        checkOutput("async reset", {20'd0, bus.debug, bus.LoadR, bus.Operand}, {20'd0, 3'd0, 1'b1, 8'h00});
        bus.trig = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        ClrA = 1'b1;
        #1 checkOutput("mid release idle", 32'(bus.debug), 32'd0);
        @(posedge Clk); #1;
        checkOutput("mid release ent_a", 32'(bus.debug), 32'd1);

        // Empty B entry loads zero
        applyStimulus(4'h3, 4);
        base = cyc; pushExp(0, base + 3, 8'h03, 1'b0, 1'b0, 1'b1);
        applyStimulus(4'hA, 4);
        base = cyc;
        pushExp(1, base + 3, 8'h00, 1'b0, 1'b0, 1'b1);
        pushExp(2, base + 5, 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'hF, 4);
        checkOutput("empty b show", 32'(bus.debug), 32'd7);

        repeat (5) @(posedge Clk);
        #1;
        checkOutput("pending loads", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/calc_seq.md
# calc_seq

Keypad-driven sequencer for the two-function calculator datapath. It debounces key strobes and assembles multi-digit hex operands. It drives the A/B/R register loads and the add/subtract select. It also supports chained operations, where the previous result becomes operand A. It sits between the keypad decoder and the operand/result registers and adder, and replaces the fixed single-shot sequence with a full entry controller.

## Interface
- DIGITS, 2: maximum hex digits per operand; operand width W = 4*DIGITS
- Clk  in  1  system clock, all state on rising edge
- ClrA  in  1  asynchronous active-low reset of the whole block
- ClrE  in  1  synchronous active-low clear-entry
- trig  in  1  raw key strobe, asynchronous, high while a key is held
- value  in  4  key code, stable while trig high
- Operand  out  W  assembled operand, to A/B register inputs
- LoadA, LoadB, LoadR  out  1 each  active-low one-cycle register load strobes
- AddSub  out  1  0 = add, 1 = subtract
- SelR  out  1  high: A register sources the result register (chaining)
- ShowR  out  1  high: display shows the result
- Busy  out  1  high in LD_A, LD_B, EXEC, LD_R
- Err  out  1  sticky digit-overflow flag
- debug  out  3  current state encoding

## Operation
- Key press: trig is passed through a two-flop synchronizer. A press is its rising edge, one pulse per press regardless of hold time. value is sampled in the press cycle.
- Digits are 0x0–0x9. Operators are 0xA = add, 0xB = subtract, 0xF = equals. 0xC–0xE are ignored in every state.
- Digit entry: if cnt < DIGITS, Operand <= {Operand[W-5:0], value} and cnt++. Otherwise Err <= 1 and Operand is unchanged.
- States and encodings:
  - IDLE (0) -> ENT_A unconditionally; Operand, cnt and Err are cleared.
  - ENT_A (1)
    - Digit: digit entry.
    - A/B: latch AddSub, -> LD_A.
    - F: ignored.
  - LD_A (2)
    - LoadA = 0.
    - Next cycle: clear Operand and cnt, -> ENT_B.
  - ENT_B (3)
    - Digit: digit entry.
    - A/B: re-latch AddSub and stay (operator change).
    - F: -> LD_B. An empty entry loads 0.
  - LD_B (4): LoadB = 0, -> EXEC.
  - EXEC (5): one adder-settle cycle, -> LD_R.
  - LD_R (6): LoadR = 0, -> SHOW.
  - SHOW (7): ShowR = 1.
    - Digit: clear, then shift the digit in (Operand = digit, cnt = 1), clear Err, SelR flag = 0, -> ENT_A.
    - A/B: latch AddSub, set the SelR flag, Operand = 0, -> LD_A.
    - F: ignored.
- SelR is high only in LD_A entered from SHOW; otherwise 0.
- ClrE = 0:
  - In ENT_A/ENT_B: clear Operand, cnt and Err; state and AddSub are kept.
  - In all other states: no effect.
  - On a press in the same cycle, ClrE wins and the key is dropped.
- Presses arriving in Busy states are dropped (not queued).
- Outputs are Moore-decoded from the state register; Operand, AddSub, Err and the SelR flag are registered.

## Timing
- Reset values (ClrA = 0):
  - state IDLE, debug = 0
  - LoadA = LoadB = LoadR = 1
  - AddSub = 0, SelR = 0, ShowR = 0, Busy = 0, Err = 0
  - Operand = 0, cnt = 0, synchronizer flops = 0
- ClrA takes effect immediately, mid-sequence included. No load strobe follows the deassertion. The first cycle after release is IDLE, and ENT_A follows one cycle later.
- Press latency: 2–3 Clk from the trig rising edge to the press pulse.
- F press in ENT_B at cycle t:
  - LoadB low at t+1
  - EXEC at t+2
  - LoadR low at t+3
  - SHOW from t+4
- A/B press at cycle t: LoadA low at t+1, ENT_B from t+2.
- Each load strobe is low for exactly one cycle.

## Structure
- Shared package calc_pkg:
  - state encodings S_IDLE..S_SHOW (3-bit)
  - key constants KEY_ADD = 4'hA, KEY_SUB = 4'hB, KEY_EQ = 4'hF, KEY_DIG_MAX = 4'h9
- One sub-module, key_sync: two-flop synchronizer plus rising-edge detector, output press.
- Top holds the FSM, the operand shift register, the digit counter and the flags.

## Test plan
- Reset: ClrA low -> debug = 0, LoadA/B/R = 1, Operand = 0; release -> debug = 0 for one cycle, then 1.
- Keys 1,2,A,3,4,F:
  - LoadA pulses once with Operand = 0x12, AddSub = 0.
  - LoadB pulses once with Operand = 0x34.
  - LoadR is low 3 cycles after the F press pulse; debug ends at 7.
- Overflow/clear: 1,2,3 in ENT_A -> Operand = 0x12, Err = 1; ClrE low one cycle -> Operand = 0, Err = 0; key 5 -> Operand = 0x05.
- Chaining: in SHOW press B -> LoadA low with SelR = 1, AddSub = 1, Operand = 0; then 7,F -> LoadB with Operand = 0x07, SelR = 0.
- Hold and ignored keys: trig held 10 cycles with value = 4 -> Operand = 0x04, cnt = 1; keys C,D,E in ENT_A -> no change.
- Mid-operation reset: ClrA pulsed low during EXEC -> debug = 0 at once, no LoadR pulse, IDLE after release.
